dmem_resp: RTL

Data-memory responder serving load/store requests issued by the memory-access stage of the MIPS pipeline. Replaces the zero-latency in-stage data array with a handshaked word memory. The memory has a configurable number of wait states, byte-enable writes, and error reporting. It sits between the MA stage (initiator) and the data storage, and owns the data-memory array.

---
 rtl/dmem_resp.sv | 134 +++++++++++++
 1 files changed

// File: rtl/dmem_resp.sv
// Handshaked word-addressed data memory for the MIPS memory-access stage.
// One request is outstanding at a time. Wait states are programmable, stores use byte enables, and bad addresses report an error.
module dmem_resp #(
   parameter int DMEM_SIZE   = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [1:0]  dbg_state_o
);

   localparam int IDX_W = (DMEM_SIZE > 1) ? $clog2(DMEM_SIZE) : 1;

   // Handshake: a transfer happens on a rising edge where valid and ready are both high.
   // The request channel is ready only in IDLE and only when out of reset.
   // A response is held, unchanged, until the edge where rsp_ready is high.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;
   logic        rsp_valid_q;
   logic [31:0] rsp_rdata_q;
   logic        rsp_err_q;

   logic [31:0] mem [DMEM_SIZE];

   logic             accept;
   logic             in_idle;
   logic             enter_resp;
   logic             acc_we;
   logic [31:0]      acc_addr;
   logic [31:0]      acc_wdata;
   logic [3:0]       acc_be;
   logic             acc_err;
   logic [IDX_W-1:0] acc_idx;
   logic [31:0]      rd_word;
   logic             mem_we;

   assign req_ready = (state_q == S_IDLE) && RST;
   assign accept    = req_valid && req_ready;
   assign in_idle   = (state_q == S_IDLE);

   // With zero wait states the access happens on the acceptance edge, so it uses the live request.
   assign acc_we    = in_idle ? req_we    : we_q;
   assign acc_addr  = in_idle ? req_addr  : addr_q;
   assign acc_wdata = in_idle ? req_wdata : wdata_q;
   assign acc_be    = in_idle ? req_be    : be_q;

   assign enter_resp = RST && ((accept && (WAIT_CYCLES == 0)) ||
                               ((state_q == S_WAIT) && (cnt_q == 8'd1)));

   assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DMEM_SIZE));
   assign acc_idx = acc_addr[IDX_W+1:2];
   assign rd_word = mem[acc_idx];
   assign mem_we  = enter_resp && acc_we && !acc_err;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         we_q        <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         be_q        <= 4'd0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  be_q    <= req_be;
                  cnt_q   <= 8'(WAIT_CYCLES);
                  state_q <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_q - 8'd1;
               if (cnt_q == 8'd1) state_q <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state_q     <= S_IDLE;
                  rsp_valid_q <= 1'b0;
                  rsp_rdata_q <= 32'd0;
                  rsp_err_q   <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
         if (enter_resp) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= acc_err;
            rsp_rdata_q <= (acc_err || acc_we) ? 32'd0 : rd_word;
         end
      end
   end

   // Storage is deliberately not reset; a reset edge never commits because enter_resp is gated by RST.
   always_ff @(posedge CLK) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
         end
      end
   end

   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign dbg_state_o = state_q;

endmodule
